// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a rotating-priority pick, held grants and an optional hold timeout.
// One grant at a time; every release is followed by at least one idle cycle.
module rr_grant_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic [WIDTH-1:0]         req_i,
    input  logic                     done_i,
    output logic [WIDTH-1:0]         grant_o,
    output logic [$clog2(WIDTH)-1:0] grant_idx_o,
    output logic                     grant_val_o,
    output logic                     timeout_o,
    output logic                     dbg_state_o
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] LAST_CNT = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] TOP_IDX  = IW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;

    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;
    logic          found_hi;
    logic [IW-1:0] win_idx;
    logic          expired;
    logic          owner_req;
    logic          release_now;

    assign dbg_state_o = state;

    // Scanning from the top down leaves the lowest qualifying bit in each index.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        found_hi = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx = IW'(i);
                if (i >= int'(ptr)) begin
                    hi_idx   = IW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win_idx = found_hi ? hi_idx : lo_idx;
    end

    assign expired     = (MAX_HOLD != 0) && (cnt == LAST_CNT);
    assign owner_req   = req_i[grant_idx_o];
    assign release_now = done_i || !owner_req || expired;

    // grant_val_o qualifies grant_o/grant_idx_o; there is no ready, the owner
    // keeps the resource until it raises done_i, drops its request or times out.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            grant_o     <= '0;
            grant_idx_o <= '0;
            grant_val_o <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout_o <= 1'b0;
                    cnt       <= '0;
                    if (|req_i) begin
                        state       <= GRANT;
                        grant_o     <= WIDTH'(1) << win_idx;
                        grant_idx_o <= win_idx;
                        grant_val_o <= 1'b1;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state       <= IDLE;
                        grant_o     <= '0;
                        grant_idx_o <= '0;
                        grant_val_o <= 1'b0;
                        cnt         <= '0;
                        ptr         <= (grant_idx_o == TOP_IDX) ? '0 : grant_idx_o + 1'b1;
                        timeout_o   <= !done_i && owner_req && expired;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (WIDTH=4, MAX_HOLD=8) with hand-computed expectations.
module tb_rr_grant_arbiter;

    logic       clk_i = 1'b0;
    logic       arst_i;
    logic [3:0] req_i;
    logic       done_i;
    logic [3:0] grant_o;
    logic [1:0] grant_idx_o;
    logic       grant_val_o;
    logic       timeout_o;
    logic       dbg_state_o;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_g;

    rr_grant_arbiter #(.WIDTH(4), .MAX_HOLD(8)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .req_i       (req_i),
        .done_i      (done_i),
        .grant_o     (grant_o),
        .grant_idx_o (grant_idx_o),
        .grant_val_o (grant_val_o),
        .timeout_o   (timeout_o),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] g, input logic [1:0] idx);
        check({tag, "_grant"}, 32'(grant_o), 32'(g));
        check({tag, "_idx"},   32'(grant_idx_o), 32'(idx));
        check({tag, "_val"},   32'(grant_val_o), 32'(1));
    endtask

    task automatic check_idle(input string tag, input logic to);
        check({tag, "_idle_val"},   32'(grant_val_o), 32'(0));
        check({tag, "_idle_grant"}, 32'(grant_o), 32'(0));
        check({tag, "_timeout"},    32'(timeout_o), 32'(to));
    endtask

    initial begin
        arst_i = 1'b1;
        req_i  = 4'b0000;
        done_i = 1'b0;
        #12;
        check("rst_grant", 32'(grant_o), 32'(0));
        check("rst_idx",   32'(grant_idx_o), 32'(0));
        check("rst_val",   32'(grant_val_o), 32'(0));
        check("rst_to",    32'(timeout_o), 32'(0));
        check("rst_state", 32'(dbg_state_o), 32'(0));
        tick();
        arst_i = 1'b0;

        // 1: no requests for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            check_idle("t1", 1'b0);
        end

        // 2: pick from ptr 0, then from ptr 2 after release
        req_i = 4'b1010;
        tick();
        check_grant("t2_a", 4'b0010, 2'd1);
        check("t2_state", 32'(dbg_state_o), 32'(1));
        done_i = 1'b1;
        tick();
        check_idle("t2_bubble", 1'b0);
        done_i = 1'b0;
        tick();
        check_grant("t2_b", 4'b1000, 2'd3);
        done_i = 1'b1;
        tick();
        check_idle("t2_rel", 1'b0);

        // 3: all requesting, rotation with one bubble between grants
        done_i = 1'b0;
        req_i  = 4'b1111;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        while (exp_q.size() != 0) begin
            exp_g = exp_q.pop_front();
            tick();
            check("t3_grant", 32'(grant_o), 32'(exp_g));
            check("t3_val",   32'(grant_val_o), 32'(1));
            done_i = 1'b1;
            tick();
            check_idle("t3_bubble", 1'b0);
            done_i = 1'b0;
        end

        // 4: single requester holds until timeout (ptr is 1 here)
        req_i = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_grant("t4_hold", 4'b0100, 2'd2);
            check("t4_no_to", 32'(timeout_o), 32'(0));
        end
        tick();
        check_idle("t4_expire", 1'b1);
        tick();
        check_grant("t4_regrant", 4'b0100, 2'd2);
        check("t4_to_pulse", 32'(timeout_o), 32'(0));

        // 5: owner drops its request
        done_i = 1'b1;
        tick();
        check_idle("t5_rel", 1'b0);
        done_i = 1'b0;
        req_i  = 4'b0001;
        tick();
        check_grant("t5_wrap", 4'b0001, 2'd0);
        req_i = 4'b1110;
        tick();
        check_idle("t5_drop", 1'b0);
        tick();
        check_grant("t5_next", 4'b0010, 2'd1);

        // 6: asynchronous reset in the middle of a grant
        req_i = 4'b1111;
        #2;
        arst_i = 1'b1;
        #1;
        check("t6_grant", 32'(grant_o), 32'(0));
        check("t6_idx",   32'(grant_idx_o), 32'(0));
        check("t6_val",   32'(grant_val_o), 32'(0));
        check("t6_to",    32'(timeout_o), 32'(0));
        tick();
        arst_i = 1'b0;
        tick();
        check_grant("t6_first", 4'b0001, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
